shift_in_reader: RTL and testbench



---
 rtl/shift_in_reader.sv | 159 +++++++++++++++
 tb/tb_shift_in_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_in_reader.sv
// Serial-in / parallel-out scanner for a 74HC165-style input chain.
// Optional feature: define SHIFTIN_DEBOUNCE_EN to require two identical scans before pdata updates.
module shift_in_reader #(
    parameter int WIDTH     = 16,
    parameter int DIVIDE    = 4,
    parameter int INTERVAL  = 16,
    parameter bit DIRECTION = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic             sck,
    output logic             sld,
    output logic [WIDTH-1:0] pdata,
    output logic             valid,
    output logic             busy
);

    localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [INTERVAL-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic                high_q, high_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [WIDTH-1:0]    cap_q, cap_d;
    logic [WIDTH-1:0]    pdata_q, pdata_d;
    logic                sck_q, sck_d;
    logic                sld_q, sld_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
`ifdef SHIFTIN_DEBOUNCE_EN
    logic [WIDTH-1:0]    raw_q, raw_d;
`endif

    logic ph_last;
    logic bit_last;

    assign ph_last  = (ph_q == PW'(DIVIDE - 1));
    assign bit_last = (bit_q == BW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        high_d  = high_q;
        bit_d   = bit_q;
        cap_d   = cap_q;
        pdata_d = pdata_q;
`ifdef SHIFTIN_DEBOUNCE_EN
        raw_d   = raw_q;
`endif
        case (state_q)
            IDLE: begin
                if (&cnt_q) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    ph_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (ph_last) begin
                    state_d = SHIFT;
                    ph_d    = '0;
                    high_d  = 1'b0;
                    bit_d   = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!ph_last) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!high_q) begin
                        // Sample just before the rising sck edge that advances the chain.
                        high_d = 1'b1;
                        if (DIRECTION)
                            cap_d = {cap_q[WIDTH-2:0], sin};
                        else
                            cap_d = {sin, cap_q[WIDTH-1:1]};
                    end else begin
                        high_d = 1'b0;
                        if (bit_last)
                            state_d = DONE;
                        else
                            bit_d = bit_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SHIFTIN_DEBOUNCE_EN
                if (cap_q == raw_q)
                    pdata_d = cap_q;
                raw_d = cap_q;
`else
                pdata_d = cap_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        sck_d   = (state_d == SHIFT) && high_d;
        sld_d   = (state_d != LOAD);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            high_q  <= 1'b0;
            bit_q   <= '0;
            cap_q   <= '0;
            pdata_q <= '0;
            sck_q   <= 1'b0;
            sld_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHIFTIN_DEBOUNCE_EN
            raw_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            high_q  <= high_d;
            bit_q   <= bit_d;
            cap_q   <= cap_d;
            pdata_q <= pdata_d;
            sck_q   <= sck_d;
            sld_q   <= sld_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef SHIFTIN_DEBOUNCE_EN
            raw_q   <= raw_d;
`endif
        end
    end

    assign sck   = sck_q;
    assign sld   = sld_q;
    assign pdata = pdata_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shift_in_reader.sv
// Bench for shift_in_reader: two instances (DIRECTION=1 and DIRECTION=0), each fed by a 74HC165 chain model.
// Expected pdata comes from an emitted-bit placement model, with debounce tracked when SHIFTIN_DEBOUNCE_EN is set.
module tb_shift_in_reader;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int INT = 4;
    localparam int FIRST_VALID = (1 << INT) + DIV + 2 * DIV * W;
    localparam int PERIOD      = FIRST_VALID + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin_a, sin_b;
    logic         sck_a, sld_a, valid_a, busy_a;
    logic         sck_b, sld_b, valid_b, busy_b;
    logic [W-1:0] pdata_a, pdata_b;

    logic [W-1:0] word_a = '0;
    logic [W-1:0] word_b = '0;
    int           pos_a = 0;
    int           pos_b = 0;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           exp_valid = 0;

    logic [W-1:0] mdl_raw_a, mdl_pd_a, mdl_raw_b, mdl_pd_b;

    bit           obs_to, obs_valid_again, obs_vb;
    int           obs_load_start, obs_load_len, obs_valid_cyc;
    int           obs_rises, obs_bad_high, obs_overlap, obs_busy;

    shift_in_reader #(.WIDTH(W), .DIVIDE(DIV), .INTERVAL(INT), .DIRECTION(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sin(sin_a), .sck(sck_a), .sld(sld_a),
        .pdata(pdata_a), .valid(valid_a), .busy(busy_a)
    );

    shift_in_reader #(.WIDTH(W), .DIVIDE(DIV), .INTERVAL(INT), .DIRECTION(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sin(sin_b), .sck(sck_b), .sld(sld_b),
        .pdata(pdata_b), .valid(valid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Spec cycle number: posedges seen with rst low.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic emit_bit(input logic [W-1:0] w, input int i, input bit msb_first);
        if (i < 0 || i >= W) return 1'b0;
        return msb_first ? w[W-1-i] : w[i];
    endfunction

    // Chain A emits its word MSB first, chain B LSB first; both reload while sld is low.
    always @(posedge sck_a or negedge sld_a) begin
        if (!sld_a) pos_a <= 0;
        else        pos_a <= pos_a + 1;
    end
    always @(posedge sck_b or negedge sld_b) begin
        if (!sld_b) pos_b <= 0;
        else        pos_b <= pos_b + 1;
    end
    assign sin_a = emit_bit(word_a, pos_a, 1'b1);
    assign sin_b = emit_bit(word_b, pos_b, 1'b0);

    // i-th emitted bit lands at W-1-i (dir=1) or i (dir=0).
    function automatic logic [W-1:0] model_capture(input logic [W-1:0] w, input bit msb_first, input bit dir);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            r[dir ? (W - 1 - i) : i] = emit_bit(w, i, msb_first);
        return r;
    endfunction

    task automatic model_done(input logic [W-1:0] cap, inout logic [W-1:0] raw, inout logic [W-1:0] pd);
`ifdef SHIFTIN_DEBOUNCE_EN
        if (cap == raw) pd = cap;
        raw = cap;
`else
        pd  = cap;
        raw = cap;
`endif
    endtask

    task automatic model_reset();
        mdl_raw_a = '0; mdl_pd_a = '0;
        mdl_raw_b = '0; mdl_pd_b = '0;
    endtask

    // Watches one complete scan on instance A, returning on the negedge after valid.
    task automatic observe_scan();
        int run;
        bit prev_sck;
        obs_to = 1'b1; obs_valid_again = 1'b0; obs_vb = 1'b0;
        obs_load_start = -1; obs_load_len = 0; obs_valid_cyc = -1;
        obs_rises = 0; obs_bad_high = 0; obs_overlap = 0; obs_busy = 0;
        prev_sck = sck_a;
        run = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!sld_a) begin
                if (obs_load_len == 0) obs_load_start = cyc;
                obs_load_len++;
            end
            if (!sld_a && sck_a) obs_overlap++;
            if (busy_a) obs_busy++;
            if (sck_a) begin
                if (!prev_sck) obs_rises++;
                run++;
            end else if (prev_sck) begin
                if (run != DIV) obs_bad_high++;
                run = 0;
            end
            prev_sck = sck_a;
            if (valid_a) begin
                obs_valid_cyc = cyc;
                obs_vb = valid_b;
                @(negedge clk);
                obs_valid_again = valid_a;
                obs_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({sck_a, sld_a, valid_a, busy_a} !== 4'b0100) begin
            bad++; $display("[TB] FAIL reset_ctrl_a: got %b expected 0100", {sck_a, sld_a, valid_a, busy_a});
        end
        total++;
        if ({sck_b, sld_b, valid_b, busy_b} !== 4'b0100) begin
            bad++; $display("[TB] FAIL reset_ctrl_b: got %b expected 0100", {sck_b, sld_b, valid_b, busy_b});
        end
        total++;
        if (pdata_a !== '0) begin
            bad++; $display("[TB] FAIL reset_pdata_a: got %h expected 0000", pdata_a);
        end
        total++;
        if (pdata_b !== '0) begin
            bad++; $display("[TB] FAIL reset_pdata_b: got %h expected 0000", pdata_b);
        end
        rst = 1'b0;
        exp_valid = FIRST_VALID;
    endtask

    task automatic test_first_scan();
        observe_scan();
        total++;
        if (obs_to) begin
            bad++; $display("[TB] FAIL first_scan_timeout: got no valid expected valid at %0d", exp_valid);
            return;
        end
        total++;
        if (obs_load_start != (1 << INT)) begin
            bad++; $display("[TB] FAIL load_start: got %0d expected %0d", obs_load_start, 1 << INT);
        end
        total++;
        if (obs_load_len != DIV) begin
            bad++; $display("[TB] FAIL load_len: got %0d expected %0d", obs_load_len, DIV);
        end
        total++;
        if (obs_valid_cyc != exp_valid) begin
            bad++; $display("[TB] FAIL valid_cycle: got %0d expected %0d", obs_valid_cyc, exp_valid);
        end
        total++;
        if (obs_valid_again !== 1'b0) begin
            bad++; $display("[TB] FAIL valid_width: got %b expected 0", obs_valid_again);
        end
        total++;
        if (obs_vb !== 1'b1) begin
            bad++; $display("[TB] FAIL valid_b_sync: got %b expected 1", obs_vb);
        end
        total++;
        if (obs_rises != W) begin
            bad++; $display("[TB] FAIL sck_rises: got %0d expected %0d", obs_rises, W);
        end
        total++;
        if (obs_bad_high != 0) begin
            bad++; $display("[TB] FAIL sck_high_len: got %0d bad phases expected 0", obs_bad_high);
        end
        total++;
        if (obs_overlap != 0) begin
            bad++; $display("[TB] FAIL sld_sck_overlap: got %0d expected 0", obs_overlap);
        end
        total++;
        if (obs_busy != FIRST_VALID - (1 << INT) + 1) begin
            bad++; $display("[TB] FAIL busy_cycles: got %0d expected %0d", obs_busy, FIRST_VALID - (1 << INT) + 1);
        end
        model_done(model_capture(word_a, 1'b1, 1'b1), mdl_raw_a, mdl_pd_a);
        model_done(model_capture(word_b, 1'b0, 1'b0), mdl_raw_b, mdl_pd_b);
        total++;
        if (pdata_a !== mdl_pd_a) begin
            bad++; $display("[TB] FAIL first_pdata_a: got %h expected %h", pdata_a, mdl_pd_a);
        end
        total++;
        if (pdata_b !== mdl_pd_b) begin
            bad++; $display("[TB] FAIL first_pdata_b: got %h expected %h", pdata_b, mdl_pd_b);
        end
        exp_valid += PERIOD;
    endtask

    // Runs n scans with the current chain words, checking period, sck count and pdata each time.
    task automatic test_scans(input string name, input int n);
        for (int s = 0; s < n; s++) begin
            observe_scan();
            total++;
            if (obs_to) begin
                bad++; $display("[TB] FAIL %s_timeout: got no valid expected valid at %0d", name, exp_valid);
                return;
            end
            total++;
            if (obs_valid_cyc != exp_valid || obs_valid_again !== 1'b0) begin
                bad++; $display("[TB] FAIL %s_valid: got cycle %0d (next %b) expected cycle %0d (next 0)",
                                name, obs_valid_cyc, obs_valid_again, exp_valid);
            end
            total++;
            if (obs_rises != W || obs_bad_high != 0 || obs_overlap != 0) begin
                bad++; $display("[TB] FAIL %s_sck: got rises=%0d badhigh=%0d overlap=%0d expected %0d/0/0",
                                name, obs_rises, obs_bad_high, obs_overlap, W);
            end
            model_done(model_capture(word_a, 1'b1, 1'b1), mdl_raw_a, mdl_pd_a);
            model_done(model_capture(word_b, 1'b0, 1'b0), mdl_raw_b, mdl_pd_b);
            total++;
            if (pdata_a !== mdl_pd_a) begin
                bad++; $display("[TB] FAIL %s_pdata_a: got %h expected %h", name, pdata_a, mdl_pd_a);
            end
            total++;
            if (pdata_b !== mdl_pd_b) begin
                bad++; $display("[TB] FAIL %s_pdata_b: got %h expected %h", name, pdata_b, mdl_pd_b);
            end
            exp_valid += PERIOD;
        end
    endtask

    task automatic test_back_to_back();
        test_scans("second", 1);
        word_a = 16'hFFFF;
        word_b = 16'h0003;
        test_scans("hold_ffff", 2);
        word_a = 16'h0001;
        test_scans("change_0001", 2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                word_a = W'($urandom);
                word_b = W'($urandom);
            end
            test_scans("random", 1);
        end
    endtask

    task automatic test_mid_reset();
        int  rises;
        bit  prev;
        bit  found;
        word_a = 16'hA5C3;
        rises = 0;
        prev = sck_a;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (sck_a && !prev) rises++;
            prev = sck_a;
            if (rises == 7) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("[TB] FAIL midreset_timeout: got %0d rises expected 7", rises);
            return;
        end
        repeat (DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({sck_a, sld_a, valid_a, busy_a} !== 4'b0100) begin
            bad++; $display("[TB] FAIL midreset_ctrl: got %b expected 0100", {sck_a, sld_a, valid_a, busy_a});
        end
        total++;
        if (pdata_a !== '0 || pdata_b !== '0) begin
            bad++; $display("[TB] FAIL midreset_pdata: got %h/%h expected 0000/0000", pdata_a, pdata_b);
        end
        rst = 1'b0;
        model_reset();
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (!sld_a) found = 1'b1;
        end
        total++;
        if (!found || cyc != (1 << INT)) begin
            bad++; $display("[TB] FAIL midreset_reload: got found=%b cycle %0d expected cycle %0d",
                            found, cyc, 1 << INT);
        end
    endtask

    initial begin
        word_a = 16'hA5C3;
        word_b = 16'h8001;
        test_reset();
        test_first_scan();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
